// File: rtl/mdrs_pkg.sv
// Shared definitions for the multiply/divide reservation station (mult_div_issue_queue).
// Opcode storage is enabled by defining MDRS_OPCODE_EN.
package mdrs_pkg;

    localparam int MDRS_DATA_W = 32;
    localparam int MDRS_TAG_W  = 6;
    localparam int MDRS_OPC_W  = 3;

    // Encodings follow the RISC-V M-extension funct3 ordering
    localparam logic [2:0] OPC_MUL    = 3'd0;
    localparam logic [2:0] OPC_MULH   = 3'd1;
    localparam logic [2:0] OPC_MULHSU = 3'd2;
    localparam logic [2:0] OPC_MULHU  = 3'd3;
    localparam logic [2:0] OPC_DIV    = 3'd4;
    localparam logic [2:0] OPC_DIVU   = 3'd5;
    localparam logic [2:0] OPC_REM    = 3'd6;
    localparam logic [2:0] OPC_REMU   = 3'd7;

    // valid, rs1_val and rs2_val flags
    localparam int ENTRY_CTRL_W = 3;

    function automatic int entry_width(input int data_w, input int tag_w, input int opc_w);
        return ENTRY_CTRL_W + 2 * (data_w + tag_w) + tag_w + opc_w;
    endfunction

endpackage

// File: rtl/mdrs_entry.sv
// One reservation-station slot: load mux (dispatch / shift / hold) followed by CDB wakeup.
// Stores an opcode only when MDRS_OPCODE_EN is defined.
module mdrs_entry
    import mdrs_pkg::*;
#(
    parameter int DATA_W = MDRS_DATA_W,
    parameter int TAG_W  = MDRS_TAG_W
`ifdef MDRS_OPCODE_EN
    , parameter int OPC_W = MDRS_OPC_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load_dispatch,
    input  logic              load_shift,
    input  logic              disp_rs1_val,
    input  logic [TAG_W-1:0]  disp_rs1_tag,
    input  logic [DATA_W-1:0] disp_rs1_data,
    input  logic              disp_rs2_val,
    input  logic [TAG_W-1:0]  disp_rs2_tag,
    input  logic [DATA_W-1:0] disp_rs2_data,
    input  logic [TAG_W-1:0]  disp_rd_tag,
`ifdef MDRS_OPCODE_EN
    input  logic [OPC_W-1:0]  disp_opcode,
    input  logic [OPC_W-1:0]  shift_opcode,
    output logic [OPC_W-1:0]  opcode,
`endif
    input  logic              shift_valid,
    input  logic              shift_rs1_val,
    input  logic [TAG_W-1:0]  shift_rs1_tag,
    input  logic [DATA_W-1:0] shift_rs1_data,
    input  logic              shift_rs2_val,
    input  logic [TAG_W-1:0]  shift_rs2_tag,
    input  logic [DATA_W-1:0] shift_rs2_data,
    input  logic [TAG_W-1:0]  shift_rd_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              valid,
    output logic              rs1_val,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs2_val,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0] rs2_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              ready
);

    logic              nxt_valid;
    logic              nxt_rs1_val;
    logic [TAG_W-1:0]  nxt_rs1_tag;
    logic [DATA_W-1:0] nxt_rs1_data;
    logic              nxt_rs2_val;
    logic [TAG_W-1:0]  nxt_rs2_tag;
    logic [DATA_W-1:0] nxt_rs2_data;
    logic [TAG_W-1:0]  nxt_rd_tag;
`ifdef MDRS_OPCODE_EN
    logic [OPC_W-1:0]  nxt_opcode;
`endif

    // Wakeup is applied after the source mux, so a dispatched or shifting entry
    // picks up a same-cycle CDB result just like a resident one.
    always_comb begin
        nxt_valid    = valid;
        nxt_rs1_val  = rs1_val;
        nxt_rs1_tag  = rs1_tag;
        nxt_rs1_data = rs1_data;
        nxt_rs2_val  = rs2_val;
        nxt_rs2_tag  = rs2_tag;
        nxt_rs2_data = rs2_data;
        nxt_rd_tag   = rd_tag;
`ifdef MDRS_OPCODE_EN
        nxt_opcode   = opcode;
`endif
        if (load_dispatch) begin
            nxt_valid    = 1'b1;
            nxt_rs1_val  = disp_rs1_val;
            nxt_rs1_tag  = disp_rs1_tag;
            nxt_rs1_data = disp_rs1_data;
            nxt_rs2_val  = disp_rs2_val;
            nxt_rs2_tag  = disp_rs2_tag;
            nxt_rs2_data = disp_rs2_data;
            nxt_rd_tag   = disp_rd_tag;
`ifdef MDRS_OPCODE_EN
            nxt_opcode   = disp_opcode;
`endif
        end else if (load_shift) begin
            nxt_valid    = shift_valid;
            nxt_rs1_val  = shift_rs1_val;
            nxt_rs1_tag  = shift_rs1_tag;
            nxt_rs1_data = shift_rs1_data;
            nxt_rs2_val  = shift_rs2_val;
            nxt_rs2_tag  = shift_rs2_tag;
            nxt_rs2_data = shift_rs2_data;
            nxt_rd_tag   = shift_rd_tag;
`ifdef MDRS_OPCODE_EN
            nxt_opcode   = shift_opcode;
`endif
        end
        if (cdb_valid && nxt_valid && !nxt_rs1_val && (nxt_rs1_tag == cdb_tag)) begin
            nxt_rs1_val  = 1'b1;
            nxt_rs1_data = cdb_data;
        end
        if (cdb_valid && nxt_valid && !nxt_rs2_val && (nxt_rs2_tag == cdb_tag)) begin
            nxt_rs2_val  = 1'b1;
            nxt_rs2_data = cdb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            rs1_val  <= 1'b0;
            rs1_tag  <= '0;
            rs1_data <= '0;
            rs2_val  <= 1'b0;
            rs2_tag  <= '0;
            rs2_data <= '0;
            rd_tag   <= '0;
`ifdef MDRS_OPCODE_EN
            opcode   <= '0;
`endif
        end else if (flush) begin
            valid    <= 1'b0;
        end else begin
            valid    <= nxt_valid;
            rs1_val  <= nxt_rs1_val;
            rs1_tag  <= nxt_rs1_tag;
            rs1_data <= nxt_rs1_data;
            rs2_val  <= nxt_rs2_val;
            rs2_tag  <= nxt_rs2_tag;
            rs2_data <= nxt_rs2_data;
            rd_tag   <= nxt_rd_tag;
`ifdef MDRS_OPCODE_EN
            opcode   <= nxt_opcode;
`endif
        end
    end

    assign ready = valid && rs1_val && rs2_val;

endmodule

// File: rtl/mult_div_issue_queue.sv
// Collapsing, age-ordered mul/div reservation station feeding one non-pipelined unit.
// Define MDRS_OPCODE_EN to store and issue a per-entry opcode.
module mult_div_issue_queue
    import mdrs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = MDRS_DATA_W,
    parameter int TAG_W  = MDRS_TAG_W
`ifdef MDRS_OPCODE_EN
    , parameter int OPC_W = MDRS_OPC_W
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       dispatch_enable,
    input  logic [DATA_W-1:0]          dispatch_rs1_data,
    input  logic [DATA_W-1:0]          dispatch_rs2_data,
    input  logic [TAG_W-1:0]           dispatch_rs1_tag,
    input  logic [TAG_W-1:0]           dispatch_rs2_tag,
    input  logic                       dispatch_rs1_data_val,
    input  logic                       dispatch_rs2_data_val,
    input  logic [TAG_W-1:0]           dispatch_rd_tag,
`ifdef MDRS_OPCODE_EN
    input  logic [OPC_W-1:0]           dispatch_opcode,
    output logic [OPC_W-1:0]           issueque_opcode,
`endif
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    input  logic                       issueblk_done,
    output logic                       issueque_full,
    output logic [$clog2(DEPTH+1)-1:0] issueque_count,
    output logic                       issueque_ready,
    output logic [DATA_W-1:0]          issueque_rs1_data,
    output logic [DATA_W-1:0]          issueque_rs2_data,
    output logic [TAG_W-1:0]           issueque_rd_tag
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              e_valid    [DEPTH];
    logic              e_rs1_val  [DEPTH];
    logic [TAG_W-1:0]  e_rs1_tag  [DEPTH];
    logic [DATA_W-1:0] e_rs1_data [DEPTH];
    logic              e_rs2_val  [DEPTH];
    logic [TAG_W-1:0]  e_rs2_tag  [DEPTH];
    logic [DATA_W-1:0] e_rs2_data [DEPTH];
    logic [TAG_W-1:0]  e_rd_tag   [DEPTH];
`ifdef MDRS_OPCODE_EN
    logic [OPC_W-1:0]  e_opcode   [DEPTH];
    logic [OPC_W-1:0]  sel_opcode;
`endif
    logic [DEPTH-1:0]  e_ready;
    logic [DEPTH-1:0]  load_dispatch;
    logic [DEPTH-1:0]  load_shift;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  wr_idx;
    logic              has_cand;
    logic              fire;
    logic              accept;
    logic              busy;
    logic [DATA_W-1:0] sel_rs1_data;
    logic [DATA_W-1:0] sel_rs2_data;
    logic [TAG_W-1:0]  sel_rd_tag;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic              sh_valid;
        logic              sh_rs1_val;
        logic [TAG_W-1:0]  sh_rs1_tag;
        logic [DATA_W-1:0] sh_rs1_data;
        logic              sh_rs2_val;
        logic [TAG_W-1:0]  sh_rs2_tag;
        logic [DATA_W-1:0] sh_rs2_data;
        logic [TAG_W-1:0]  sh_rd_tag;
`ifdef MDRS_OPCODE_EN
        logic [OPC_W-1:0]  sh_opcode;
`endif
        if (i < DEPTH - 1) begin : g_above
            assign sh_valid    = e_valid[i+1];
            assign sh_rs1_val  = e_rs1_val[i+1];
            assign sh_rs1_tag  = e_rs1_tag[i+1];
            assign sh_rs1_data = e_rs1_data[i+1];
            assign sh_rs2_val  = e_rs2_val[i+1];
            assign sh_rs2_tag  = e_rs2_tag[i+1];
            assign sh_rs2_data = e_rs2_data[i+1];
            assign sh_rd_tag   = e_rd_tag[i+1];
`ifdef MDRS_OPCODE_EN
            assign sh_opcode   = e_opcode[i+1];
`endif
        end else begin : g_top
            assign sh_valid    = 1'b0;
            assign sh_rs1_val  = 1'b0;
            assign sh_rs1_tag  = '0;
            assign sh_rs1_data = '0;
            assign sh_rs2_val  = 1'b0;
            assign sh_rs2_tag  = '0;
            assign sh_rs2_data = '0;
            assign sh_rd_tag   = '0;
`ifdef MDRS_OPCODE_EN
            assign sh_opcode   = '0;
`endif
        end

        mdrs_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
`ifdef MDRS_OPCODE_EN
            , .OPC_W (OPC_W)
`endif
        ) u_entry (
            .clk            (clk),
            .reset          (reset),
            .flush          (flush),
            .load_dispatch  (load_dispatch[i]),
            .load_shift     (load_shift[i]),
            .disp_rs1_val   (dispatch_rs1_data_val),
            .disp_rs1_tag   (dispatch_rs1_tag),
            .disp_rs1_data  (dispatch_rs1_data),
            .disp_rs2_val   (dispatch_rs2_data_val),
            .disp_rs2_tag   (dispatch_rs2_tag),
            .disp_rs2_data  (dispatch_rs2_data),
            .disp_rd_tag    (dispatch_rd_tag),
`ifdef MDRS_OPCODE_EN
            .disp_opcode    (dispatch_opcode),
            .shift_opcode   (sh_opcode),
            .opcode         (e_opcode[i]),
`endif
            .shift_valid    (sh_valid),
            .shift_rs1_val  (sh_rs1_val),
            .shift_rs1_tag  (sh_rs1_tag),
            .shift_rs1_data (sh_rs1_data),
            .shift_rs2_val  (sh_rs2_val),
            .shift_rs2_tag  (sh_rs2_tag),
            .shift_rs2_data (sh_rs2_data),
            .shift_rd_tag   (sh_rd_tag),
            .cdb_valid      (cdb_valid),
            .cdb_tag        (cdb_tag),
            .cdb_data       (cdb_data),
            .valid          (e_valid[i]),
            .rs1_val        (e_rs1_val[i]),
            .rs1_tag        (e_rs1_tag[i]),
            .rs1_data       (e_rs1_data[i]),
            .rs2_val        (e_rs2_val[i]),
            .rs2_tag        (e_rs2_tag[i]),
            .rs2_data       (e_rs2_data[i]),
            .rd_tag         (e_rd_tag[i]),
            .ready          (e_ready[i])
        );
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(e_valid[i]);
        end
    end

    // Scanning from the top down leaves the oldest ready entry as the winner
    always_comb begin
        has_cand     = 1'b0;
        sel_idx      = '0;
        sel_rs1_data = '0;
        sel_rs2_data = '0;
        sel_rd_tag   = '0;
`ifdef MDRS_OPCODE_EN
        sel_opcode   = '0;
`endif
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (e_ready[i]) begin
                has_cand     = 1'b1;
                sel_idx      = CNT_W'(i);
                sel_rs1_data = e_rs1_data[i];
                sel_rs2_data = e_rs2_data[i];
                sel_rd_tag   = e_rd_tag[i];
`ifdef MDRS_OPCODE_EN
                sel_opcode   = e_opcode[i];
`endif
            end
        end
    end

    assign issueque_full  = (count == CNT_W'(DEPTH));
    assign issueque_count = count;
    assign fire           = has_cand && (!busy || issueblk_done);
    assign accept         = dispatch_enable && !issueque_full;

    // When an issue collapses the queue, the new entry goes into the freed tail slot
    always_comb begin
        wr_idx = fire ? (count - CNT_W'(1)) : count;
        for (int i = 0; i < DEPTH; i++) begin
            load_shift[i]    = fire && (CNT_W'(i) >= sel_idx);
            load_dispatch[i] = accept && (CNT_W'(i) == wr_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy              <= 1'b0;
            issueque_ready    <= 1'b0;
            issueque_rs1_data <= '0;
            issueque_rs2_data <= '0;
            issueque_rd_tag   <= '0;
`ifdef MDRS_OPCODE_EN
            issueque_opcode   <= '0;
`endif
        end else if (flush) begin
            busy              <= 1'b0;
            issueque_ready    <= 1'b0;
        end else begin
            issueque_ready <= fire;
            if (fire) begin
                busy              <= 1'b1;
                issueque_rs1_data <= sel_rs1_data;
                issueque_rs2_data <= sel_rs2_data;
                issueque_rd_tag   <= sel_rd_tag;
`ifdef MDRS_OPCODE_EN
                issueque_opcode   <= sel_opcode;
`endif
            end else if (issueblk_done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_issue_queue.sv
// Directed self-checking bench for mult_div_issue_queue (default DEPTH=4, DATA_W=32, TAG_W=6).
// Opcode ports are connected only when MDRS_OPCODE_EN is defined.
module tb_mult_div_issue_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        dispatch_enable;
    logic [31:0] dispatch_rs1_data;
    logic [31:0] dispatch_rs2_data;
    logic [5:0]  dispatch_rs1_tag;
    logic [5:0]  dispatch_rs2_tag;
    logic        dispatch_rs1_data_val;
    logic        dispatch_rs2_data_val;
    logic [5:0]  dispatch_rd_tag;
`ifdef MDRS_OPCODE_EN
    logic [2:0]  dispatch_opcode;
    logic [2:0]  issueque_opcode;
`endif
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issueblk_done;
    logic        issueque_full;
    logic [2:0]  issueque_count;
    logic        issueque_ready;
    logic [31:0] issueque_rs1_data;
    logic [31:0] issueque_rs2_data;
    logic [5:0]  issueque_rd_tag;

    int checks = 0;
    int errors = 0;

    mult_div_issue_queue dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .dispatch_enable       (dispatch_enable),
        .dispatch_rs1_data     (dispatch_rs1_data),
        .dispatch_rs2_data     (dispatch_rs2_data),
        .dispatch_rs1_tag      (dispatch_rs1_tag),
        .dispatch_rs2_tag      (dispatch_rs2_tag),
        .dispatch_rs1_data_val (dispatch_rs1_data_val),
        .dispatch_rs2_data_val (dispatch_rs2_data_val),
        .dispatch_rd_tag       (dispatch_rd_tag),
`ifdef MDRS_OPCODE_EN
        .dispatch_opcode       (dispatch_opcode),
        .issueque_opcode       (issueque_opcode),
`endif
        .cdb_valid             (cdb_valid),
        .cdb_tag               (cdb_tag),
        .cdb_data              (cdb_data),
        .issueblk_done         (issueblk_done),
        .issueque_full         (issueque_full),
        .issueque_count        (issueque_count),
        .issueque_ready        (issueque_ready),
        .issueque_rs1_data     (issueque_rs1_data),
        .issueque_rs2_data     (issueque_rs2_data),
        .issueque_rd_tag       (issueque_rd_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // en, rs1 data/tag/valid, rs2 data/tag/valid, destination tag
    task automatic applyStimulus(input logic en,
                                 input logic [31:0] r1, input logic [5:0] t1, input logic v1,
                                 input logic [31:0] r2, input logic [5:0] t2, input logic v2,
                                 input logic [5:0] rd);
        dispatch_enable       = en;
        dispatch_rs1_data     = r1;
        dispatch_rs1_tag      = t1;
        dispatch_rs1_data_val = v1;
        dispatch_rs2_data     = r2;
        dispatch_rs2_tag      = t2;
        dispatch_rs2_data_val = v2;
        dispatch_rd_tag       = rd;
`ifdef MDRS_OPCODE_EN
        dispatch_opcode       = rd[2:0];
`endif
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        cdb_valid     = 1'b0;
        cdb_tag       = 6'd0;
        cdb_data      = 32'h0;
        issueblk_done = 1'b0;
        idle();
        #2;
        checkOutput("reset_count", 32'(issueque_count), 32'd0);
        checkOutput("reset_full", 32'(issueque_full), 32'd0);
        checkOutput("reset_ready", 32'(issueque_ready), 32'd0);
        checkOutput("reset_rs1", issueque_rs1_data, 32'd0);
        checkOutput("reset_rs2", issueque_rs2_data, 32'd0);
        checkOutput("reset_rd", 32'(issueque_rd_tag), 32'd0);
        #10 reset = 1'b0;

        // Basic issue: fully valid dispatch issues one edge after it is written
        applyStimulus(1'b1, 32'd7, 6'd0, 1'b1, 32'd6, 6'd0, 1'b1, 6'd5);
        tick();
        idle();
        checkOutput("t1_count_after_dispatch", 32'(issueque_count), 32'd1);
        checkOutput("t1_ready_early", 32'(issueque_ready), 32'd0);
        tick();
        checkOutput("t1_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t1_rs1", issueque_rs1_data, 32'd7);
        checkOutput("t1_rs2", issueque_rs2_data, 32'd6);
        checkOutput("t1_rd", 32'(issueque_rd_tag), 32'd5);
        checkOutput("t1_count_after_issue", 32'(issueque_count), 32'd0);
        tick();
        checkOutput("t1_ready_one_cycle", 32'(issueque_ready), 32'd0);
        issueblk_done = 1'b1;
        tick();
        issueblk_done = 1'b0;

        // Younger ready entry overtakes an older waiting one; CDB wakes the older one
        applyStimulus(1'b1, 32'd0, 6'd9, 1'b0, 32'd2, 6'd0, 1'b1, 6'd10);
        tick();
        applyStimulus(1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd11);
        tick();
        idle();
        checkOutput("t2_count", 32'(issueque_count), 32'd2);
        tick();
        checkOutput("t2_b_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t2_b_rd", 32'(issueque_rd_tag), 32'd11);
        checkOutput("t2_b_rs1", issueque_rs1_data, 32'd3);
        checkOutput("t2_count_after_b", 32'(issueque_count), 32'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_data  = 32'h1234;
        tick();
        cdb_valid = 1'b0;
        checkOutput("t2_no_issue_while_busy", 32'(issueque_ready), 32'd0);
        issueblk_done = 1'b1;
        tick();
        checkOutput("t2_a_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t2_a_rs1", issueque_rs1_data, 32'h1234);
        checkOutput("t2_a_rs2", issueque_rs2_data, 32'd2);
        checkOutput("t2_a_rd", 32'(issueque_rd_tag), 32'd10);
        checkOutput("t2_count_empty", 32'(issueque_count), 32'd0);
        tick();
        issueblk_done = 1'b0;

        // Fill, drop a dispatch while full, then drain back-to-back
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'd0, 6'd3, 1'b0, 32'(100 + i), 6'd0, 1'b1, 6'(20 + i));
            tick();
        end
        checkOutput("t3_full", 32'(issueque_full), 32'd1);
        checkOutput("t3_count4", 32'(issueque_count), 32'd4);
        applyStimulus(1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd24);
        tick();
        idle();
        checkOutput("t3_count_after_drop", 32'(issueque_count), 32'd4);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd3;
        cdb_data  = 32'h33;
        tick();
        cdb_valid = 1'b0;
        checkOutput("t3_wakeup_not_same_cycle", 32'(issueque_ready), 32'd0);
        tick();
        checkOutput("t3_first_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t3_first_rd", 32'(issueque_rd_tag), 32'd20);
        checkOutput("t3_first_rs1", issueque_rs1_data, 32'h33);
        checkOutput("t3_count3", 32'(issueque_count), 32'd3);
        issueblk_done = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput("t3_b2b_ready", 32'(issueque_ready), 32'd1);
            checkOutput("t3_b2b_rd", 32'(issueque_rd_tag), 32'(20 + i));
            checkOutput("t3_b2b_rs2", issueque_rs2_data, 32'(100 + i));
        end
        checkOutput("t3_count_drained", 32'(issueque_count), 32'd0);
        tick();
        issueblk_done = 1'b0;
        checkOutput("t3_no_phantom", 32'(issueque_ready), 32'd0);

        // Dispatch bypass from a same-cycle CDB broadcast
        applyStimulus(1'b1, 32'h11, 6'd0, 1'b1, 32'd0, 6'd12, 1'b0, 6'd30);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd12;
        cdb_data  = 32'hABCD;
        tick();
        cdb_valid = 1'b0;
        idle();
        checkOutput("t4_count", 32'(issueque_count), 32'd1);
        tick();
        checkOutput("t4_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t4_rs1", issueque_rs1_data, 32'h11);
        checkOutput("t4_rs2", issueque_rs2_data, 32'hABCD);
        checkOutput("t4_rd", 32'(issueque_rd_tag), 32'd30);

        // Issue + dispatch in the same cycle while the unit was busy
        applyStimulus(1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd40);
        tick();
        applyStimulus(1'b1, 32'd0, 6'd50, 1'b0, 32'd9, 6'd0, 1'b1, 6'd42);
        tick();
        checkOutput("t5_busy_blocks", 32'(issueque_ready), 32'd0);
        checkOutput("t5_count2", 32'(issueque_count), 32'd2);
        applyStimulus(1'b1, 32'd5, 6'd0, 1'b1, 32'd6, 6'd0, 1'b1, 6'd41);
        issueblk_done = 1'b1;
        tick();
        idle();
        issueblk_done = 1'b0;
        checkOutput("t5_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t5_rd", 32'(issueque_rd_tag), 32'd40);
        checkOutput("t5_count_unchanged", 32'(issueque_count), 32'd2);
        tick();
        checkOutput("t5_wait_done", 32'(issueque_ready), 32'd0);
        issueblk_done = 1'b1;
        tick();
        issueblk_done = 1'b0;
        checkOutput("t5_tail_ready", 32'(issueque_ready), 32'd1);
        checkOutput("t5_tail_rd", 32'(issueque_rd_tag), 32'd41);
        checkOutput("t5_tail_rs1", issueque_rs1_data, 32'd5);
        checkOutput("t5_count1", 32'(issueque_count), 32'd1);

        // Asynchronous reset between edges with 3 entries and busy set
        applyStimulus(1'b1, 32'd0, 6'd50, 1'b0, 32'd1, 6'd0, 1'b1, 6'd43);
        tick();
        applyStimulus(1'b1, 32'd0, 6'd50, 1'b0, 32'd1, 6'd0, 1'b1, 6'd44);
        tick();
        idle();
        checkOutput("t6_count3", 32'(issueque_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_rst_count", 32'(issueque_count), 32'd0);
        checkOutput("t6_rst_full", 32'(issueque_full), 32'd0);
        checkOutput("t6_rst_rs1", issueque_rs1_data, 32'd0);
        checkOutput("t6_rst_rs2", issueque_rs2_data, 32'd0);
        checkOutput("t6_rst_rd", 32'(issueque_rd_tag), 32'd0);
        #1 reset = 1'b0;
        issueblk_done = 1'b1;
        tick();
        issueblk_done = 1'b0;
        checkOutput("t6_late_done_ignored", 32'(issueque_ready), 32'd0);
        applyStimulus(1'b1, 32'd8, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 6'd45);
        tick();
        idle();
        tick();
        checkOutput("t6_not_busy_after_reset", 32'(issueque_ready), 32'd1);
        checkOutput("t6_rd45", 32'(issueque_rd_tag), 32'd45);
        issueblk_done = 1'b1;
        tick();
        issueblk_done = 1'b0;

        // Flush beats a pending issue
        applyStimulus(1'b1, 32'd0, 6'd60, 1'b0, 32'd1, 6'd0, 1'b1, 6'd50);
        tick();
        applyStimulus(1'b1, 32'd7, 6'd0, 1'b1, 32'd8, 6'd0, 1'b1, 6'd51);
        tick();
        idle();
        checkOutput("t7_count2", 32'(issueque_count), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t7_flush_count", 32'(issueque_count), 32'd0);
        checkOutput("t7_flush_no_issue", 32'(issueque_ready), 32'd0);
        tick();
        checkOutput("t7_still_idle", 32'(issueque_ready), 32'd0);
        checkOutput("t7_still_empty", 32'(issueque_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
